// File: rtl/data_mem_ctrl.sv
// MEM-stage data-memory access controller: one load/store at a time, pipeline stalled
// while the RAM access is in flight, raw read word and address handed to extraction.
module data_mem_ctrl #(
   parameter int ADDR_WIDTH  = 32,
   parameter int WAIT_STATES = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [ADDR_WIDTH-1:0] write_data_i,
   input  logic [1:0]            mem_type_i,
   output logic                  stall_o,
   output logic                  done_o,
   output logic                  misalign_o,
   output logic [ADDR_WIDTH-1:0] read_data_o,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic                  ram_en_o,
   output logic                  ram_we_o,
   output logic [3:0]            ram_be_o,
   output logic [ADDR_WIDTH-3:0] ram_addr_o,
   output logic [ADDR_WIDTH-1:0] ram_wdata_o,
   input  logic [ADDR_WIDTH-1:0] ram_rdata_i
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, DONE} state_t;

   localparam logic [1:0] LP_BYTE      = 2'b01;
   localparam logic [1:0] LP_HALF      = 2'b10;
   localparam logic [3:0] LP_WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_t                r_state;
   state_t                w_next_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [ADDR_WIDTH-1:0] r_wdata;
   logic [ADDR_WIDTH-1:0] r_read_data;
   logic [1:0]            r_type;
   logic [3:0]            r_cnt;
   logic                  r_we;
   logic                  r_misalign;
   logic                  w_misalign;
   logic [3:0]            w_be;
   logic [ADDR_WIDTH-1:0] w_wdata;

   // NOTE: every always_comb assigns defaults first so no path can infer a latch.
   always_comb begin
      w_misalign = 1'b0;
      case (mem_type_i)
         LP_BYTE: w_misalign = 1'b0;
         LP_HALF: w_misalign = addr_i[0];
         default: w_misalign = |addr_i[1:0];
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      ram_en_o     = 1'b0;
      ram_we_o     = 1'b0;
      ram_be_o     = 4'b0000;
      done_o       = 1'b0;
      stall_o      = req_i && (r_state != DONE);
      case (r_state)
         IDLE:    if (req_i) w_next_state = w_misalign ? DONE : ISSUE;
         ISSUE: begin
            ram_en_o     = 1'b1;
            ram_we_o     = r_we;
            ram_be_o     = w_be;
            w_next_state = (WAIT_STATES > 0) ? WAIT : CAPTURE;
         end
         WAIT:    if (r_cnt == LP_WAIT_LAST) w_next_state = CAPTURE;
         CAPTURE: w_next_state = DONE;
         DONE: begin
            done_o       = 1'b1;
            w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Lane selection and replication work off the latched request, not the live inputs.
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = r_wdata;
      case (r_type)
         LP_BYTE: begin
            w_be    = 4'b0001 << r_addr[1:0];
            w_wdata = {(ADDR_WIDTH/8){r_wdata[7:0]}};
         end
         LP_HALF: begin
            w_be    = 4'b0011 << {r_addr[1], 1'b0};
            w_wdata = {(ADDR_WIDTH/16){r_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // NOTE: non-blocking assignments so every register samples the pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr      <= '0;
         r_wdata     <= '0;
         r_read_data <= '0;
         r_type      <= 2'b00;
         r_cnt       <= 4'd0;
         r_we        <= 1'b0;
         r_misalign  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_i) begin
                  r_addr     <= addr_i;
                  r_misalign <= w_misalign;
                  if (!w_misalign) begin
                     r_we    <= we_i;
                     r_type  <= mem_type_i;
                     r_wdata <= write_data_i;
                  end
               end
            end
            WAIT:    r_cnt <= (r_cnt == LP_WAIT_LAST) ? 4'd0 : r_cnt + 4'd1;
            CAPTURE: if (!r_we) r_read_data <= ram_rdata_i;
            DONE:    r_misalign <= 1'b0;
            default: ;
         endcase
      end
   end

   assign misalign_o  = r_misalign;
   assign read_data_o = r_read_data;
   assign addr_o      = r_addr;
   assign ram_addr_o  = r_addr[ADDR_WIDTH-1:2];
   assign ram_wdata_o = w_wdata;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: a vector table on a zero-wait instance plus
// hand-written multi-cycle sequences (latency, back-to-back, reset) on a 3-wait instance.
module tb_data_mem_ctrl;

   localparam logic [31:0] GARB = 32'h0BAD_0BAD;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [1:0]  mt;
      logic [31:0] ram_word;
      logic        exp_mis;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   logic clk;
   int   n_tests = 0;
   int   n_fail  = 0;

   // zero-wait instance
   logic        rst0, req0, we0, stall0, done0, mis0, en0, rwe0;
   logic [31:0] addr0, wd0, rd0, ao0, rwd0, rrd0, ram_word0;
   logic [1:0]  mt0;
   logic [3:0]  be0;
   logic [29:0] raddr0;

   // three-wait instance
   logic        rst3, req3, we3, stall3, done3, mis3, en3, rwe3;
   logic [31:0] addr3, wd3, rd3, ao3, rwd3, rrd3, ram_word3;
   logic [1:0]  mt3;
   logic [3:0]  be3;
   logic [29:0] raddr3;
   int          lat3;

   data_mem_ctrl #(.ADDR_WIDTH(32), .WAIT_STATES(0)) u_dut0 (
      .clk(clk), .rst(rst0), .req_i(req0), .we_i(we0), .addr_i(addr0),
      .write_data_i(wd0), .mem_type_i(mt0), .stall_o(stall0), .done_o(done0),
      .misalign_o(mis0), .read_data_o(rd0), .addr_o(ao0), .ram_en_o(en0),
      .ram_we_o(rwe0), .ram_be_o(be0), .ram_addr_o(raddr0), .ram_wdata_o(rwd0),
      .ram_rdata_i(rrd0)
   );

   data_mem_ctrl #(.ADDR_WIDTH(32), .WAIT_STATES(3)) u_dut3 (
      .clk(clk), .rst(rst3), .req_i(req3), .we_i(we3), .addr_i(addr3),
      .write_data_i(wd3), .mem_type_i(mt3), .stall_o(stall3), .done_o(done3),
      .misalign_o(mis3), .read_data_o(rd3), .addr_o(ao3), .ram_en_o(en3),
      .ram_we_o(rwe3), .ram_be_o(be3), .ram_addr_o(raddr3), .ram_wdata_o(rwd3),
      .ram_rdata_i(rrd3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM models: read word appears 1+W cycles after the ram_en cycle, held afterwards.
   always @(posedge clk) begin
      if (en0 && !rwe0) rrd0 <= ram_word0;
   end

   always @(posedge clk) begin
      if (en3 && !rwe3) begin
         rrd3 <= GARB;
         lat3 <= 3;
      end else if (lat3 > 0) begin
         if (lat3 == 1) rrd3 <= ram_word3;
         lat3 <= lat3 - 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int i);
      @(negedge clk);
      req0 = 1'b1; we0 = v.we; addr0 = v.addr; wd0 = v.wd; mt0 = v.mt;
      ram_word0 = v.ram_word;
      #1;
      check($sformatf("v%0d c0 stall", i), stall0, 1'b1);
      check($sformatf("v%0d c0 en", i), en0, 1'b0);
      @(negedge clk); #1;
      if (v.exp_mis) begin
         check($sformatf("v%0d c1 done", i), done0, 1'b1);
         check($sformatf("v%0d c1 misalign", i), mis0, 1'b1);
         check($sformatf("v%0d c1 en", i), en0, 1'b0);
         check($sformatf("v%0d c1 ram_we", i), rwe0, 1'b0);
         check($sformatf("v%0d c1 be", i), be0, 4'b0000);
         check($sformatf("v%0d c1 stall", i), stall0, 1'b0);
         check($sformatf("v%0d c1 rdata", i), rd0, v.exp_rdata);
         check($sformatf("v%0d c1 addr_o", i), ao0, v.addr);
      end else begin
         check($sformatf("v%0d c1 en", i), en0, 1'b1);
         check($sformatf("v%0d c1 ram_we", i), rwe0, v.we);
         check($sformatf("v%0d c1 be", i), be0, v.exp_be);
         check($sformatf("v%0d c1 wdata", i), rwd0, v.exp_wdata);
         check($sformatf("v%0d c1 ram_addr", i), raddr0, v.addr >> 2);
         check($sformatf("v%0d c1 stall", i), stall0, 1'b1);
         check($sformatf("v%0d c1 done", i), done0, 1'b0);
         @(negedge clk); #1;
         check($sformatf("v%0d c2 en", i), en0, 1'b0);
         check($sformatf("v%0d c2 be", i), be0, 4'b0000);
         check($sformatf("v%0d c2 ram_we", i), rwe0, 1'b0);
         check($sformatf("v%0d c2 stall", i), stall0, 1'b1);
         @(negedge clk); #1;
         check($sformatf("v%0d c3 done", i), done0, 1'b1);
         check($sformatf("v%0d c3 misalign", i), mis0, 1'b0);
         check($sformatf("v%0d c3 rdata", i), rd0, v.exp_rdata);
         check($sformatf("v%0d c3 addr_o", i), ao0, v.addr);
         check($sformatf("v%0d c3 stall", i), stall0, 1'b0);
      end
      @(negedge clk);
      req0 = 1'b0;
      #1;
      check($sformatf("v%0d post done", i), done0, 1'b0);
      check($sformatf("v%0d post misalign", i), mis0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[12];
      //           we    addr          wd            mt     ram_word      mis   be       wdata         rdata
      vecs[0]  = '{1'b0, 32'h0000_0100, 32'h0000_0000, 2'b00, 32'hDEAD_BEEF, 1'b0, 4'b1111, 32'h0000_0000, 32'hDEAD_BEEF};
      vecs[1]  = '{1'b1, 32'h0000_0103, 32'h0000_00A5, 2'b01, 32'h0000_0000, 1'b0, 4'b1000, 32'hA5A5_A5A5, 32'hDEAD_BEEF};
      vecs[2]  = '{1'b1, 32'h0000_0102, 32'h1234_BEEF, 2'b10, 32'h0000_0000, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'hDEAD_BEEF};
      vecs[3]  = '{1'b1, 32'h0000_0104, 32'hCAFE_F00D, 2'b00, 32'h0000_0000, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'hDEAD_BEEF};
      vecs[4]  = '{1'b0, 32'h0000_0101, 32'h0000_0000, 2'b10, 32'h1111_1111, 1'b1, 4'b0000, 32'h0000_0000, 32'hDEAD_BEEF};
      vecs[5]  = '{1'b0, 32'h0000_0102, 32'h0000_0000, 2'b00, 32'h2222_2222, 1'b1, 4'b0000, 32'h0000_0000, 32'hDEAD_BEEF};
      vecs[6]  = '{1'b0, 32'h0000_0202, 32'h0000_0077, 2'b01, 32'h1122_3344, 1'b0, 4'b0100, 32'h7777_7777, 32'h1122_3344};
      vecs[7]  = '{1'b1, 32'h0000_0100, 32'h0000_ABCD, 2'b10, 32'h0000_0000, 1'b0, 4'b0011, 32'hABCD_ABCD, 32'h1122_3344};
      vecs[8]  = '{1'b0, 32'h0000_0206, 32'h0000_0000, 2'b10, 32'h55AA_55AA, 1'b0, 4'b1100, 32'h0000_0000, 32'h55AA_55AA};
      vecs[9]  = '{1'b1, 32'h0000_03FD, 32'hFFFF_FF3C, 2'b01, 32'h0000_0000, 1'b0, 4'b0010, 32'h3C3C_3C3C, 32'h55AA_55AA};
      vecs[10] = '{1'b1, 32'h0000_0301, 32'h9999_9999, 2'b11, 32'h0000_0000, 1'b1, 4'b0000, 32'h0000_0000, 32'h55AA_55AA};
      vecs[11] = '{1'b0, 32'h0000_03FC, 32'h0000_0000, 2'b11, 32'hA5C3_0F96, 1'b0, 4'b1111, 32'h0000_0000, 32'hA5C3_0F96};

      rst0 = 1'b1; req0 = 1'b0; we0 = 1'b0; addr0 = '0; wd0 = '0; mt0 = 2'b00; ram_word0 = '0;
      rst3 = 1'b1; req3 = 1'b0; we3 = 1'b0; addr3 = '0; wd3 = '0; mt3 = 2'b00; ram_word3 = '0;
      rrd0 = GARB; rrd3 = GARB; lat3 = 0;
      repeat (3) @(negedge clk);
      #1;
      check("rst0 stall", stall0, 1'b0);
      check("rst0 done", done0, 1'b0);
      check("rst0 rdata", rd0, 32'h0);
      check("rst0 addr_o", ao0, 32'h0);
      check("rst0 en", en0, 1'b0);
      check("rst3 done", done3, 1'b0);
      check("rst3 en", en3, 1'b0);
      @(negedge clk);
      rst0 = 1'b0; rst3 = 1'b0;

      for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

      // request dropped mid-access: completes anyway, stall follows req
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'h0000_010C; wd0 = 32'h0102_0304; mt0 = 2'b00;
      @(negedge clk); #1;
      check("drop c1 en", en0, 1'b1);
      @(negedge clk);
      req0 = 1'b0;
      #1;
      check("drop c2 stall", stall0, 1'b0);
      @(negedge clk); #1;
      check("drop c3 done", done0, 1'b1);
      check("drop c3 rdata", rd0, 32'hA5C3_0F96);

      // three wait states: LBU 0x203, then a back-to-back store
      @(negedge clk);
      req3 = 1'b1; we3 = 1'b0; addr3 = 32'h0000_0203; wd3 = '0; mt3 = 2'b01;
      ram_word3 = 32'h80FF_0011;
      #1;
      check("w3 c0 stall", stall3, 1'b1);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk); #1;
         check($sformatf("w3 c%0d en", c), en3, c == 1);
         check($sformatf("w3 c%0d be", c), be3, (c == 1) ? 4'b1000 : 4'b0000);
         check($sformatf("w3 c%0d stall", c), stall3, c <= 5);
         check($sformatf("w3 c%0d done", c), done3, c == 6);
         check($sformatf("w3 c%0d rdata", c), rd3, (c == 6) ? 32'h80FF_0011 : 32'h0);
      end
      check("w3 c6 addr_o lsb", ao3[1:0], 2'b11);
      check("w3 c6 addr_o", ao3, 32'h0000_0203);
      @(negedge clk);
      req3 = 1'b1; we3 = 1'b1; addr3 = 32'h0000_0208; wd3 = 32'h0BAD_F00D; mt3 = 2'b00;
      #1;
      check("b2b c7 stall", stall3, 1'b1);
      @(negedge clk); #1;
      check("b2b c8 en", en3, 1'b1);
      check("b2b c8 ram_we", rwe3, 1'b1);
      check("b2b c8 be", be3, 4'b1111);
      check("b2b c8 wdata", rwd3, 32'h0BAD_F00D);
      check("b2b c8 ram_addr", raddr3, 32'h0000_0082);
      for (int c = 9; c <= 13; c++) begin
         @(negedge clk); #1;
         check($sformatf("b2b c%0d en", c), en3, 1'b0);
         check($sformatf("b2b c%0d done", c), done3, c == 13);
      end
      check("b2b c13 rdata", rd3, 32'h80FF_0011);
      @(negedge clk);
      req3 = 1'b0;

      // reset asserted mid-WAIT aborts the load
      @(negedge clk);
      req3 = 1'b1; we3 = 1'b0; addr3 = 32'h0000_0300; mt3 = 2'b00; ram_word3 = 32'h1234_5678;
      repeat (3) @(negedge clk);
      rst3 = 1'b1; req3 = 1'b0;
      #1;
      check("rstw stall", stall3, 1'b0);
      check("rstw done", done3, 1'b0);
      check("rstw misalign", mis3, 1'b0);
      check("rstw rdata", rd3, 32'h0);
      check("rstw addr_o", ao3, 32'h0);
      check("rstw en", en3, 1'b0);
      check("rstw ram_we", rwe3, 1'b0);
      check("rstw be", be3, 4'b0000);
      check("rstw ram_addr", raddr3, 32'h0);
      check("rstw wdata", rwd3, 32'h0);
      @(negedge clk);
      rst3 = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk); #1;
         check($sformatf("post-rst c%0d en", c), en3, 1'b0);
         check($sformatf("post-rst c%0d done", c), done3, 1'b0);
         check($sformatf("post-rst c%0d stall", c), stall3, 1'b0);
      end

      // controller back in IDLE: a fresh load goes straight to ISSUE
      @(negedge clk);
      req3 = 1'b1;
      #1;
      check("recov c0 stall", stall3, 1'b1);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk); #1;
         check($sformatf("recov c%0d en", c), en3, c == 1);
         check($sformatf("recov c%0d done", c), done3, c == 6);
      end
      check("recov c6 rdata", rd3, 32'h1234_5678);
      @(negedge clk);
      req3 = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
